// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : ALU result queue. It computes {C,Z,N,V} flags when a result is
//            pushed and returns entries in FIFO order. Defining the macro
//            ALU_RESULT_STAGE_STICKY_FLAGS_EN enables the sticky flag register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_op,
    output logic [3:0]  out_flags,
    input  logic        sticky_clr,
    output logic [3:0]  sticky_flags
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [3:0]         c_op_add  = 4'b0010;
    localparam logic [3:0]         c_op_addx = 4'b1010;
    localparam logic [3:0]         c_op_sub  = 4'b0110;

    logic [31:0]        r_mem_result [DEPTH];
    logic [3:0]         r_mem_op     [DEPTH];
    logic [3:0]         r_mem_flags  [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_add_carry;
    logic [31:0] w_unused_sum;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_flags;

    // in_ready depends only on the registered count, never on out_ready
    assign in_ready  = (r_count < c_full);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign {w_add_carry, w_unused_sum} = {1'b0, in_a} + {1'b0, in_b};

    always_comb begin
        w_c = 1'b0;
        w_v = 1'b0;
        if (in_op == c_op_add || in_op == c_op_addx) begin
            w_c = w_add_carry;
            w_v = (in_a[31] == in_b[31]) & (in_result[31] != in_a[31]);
        end else if (in_op == c_op_sub) begin
            w_c = (in_a >= in_b);
            w_v = (in_a[31] != in_b[31]) & (in_result[31] != in_a[31]);
        end
        w_flags = {w_c, (in_result == 32'd0), in_result[31], w_v};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared so the head fields read zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_result[i] <= '0;
                r_mem_op[i]     <= '0;
                r_mem_flags[i]  <= '0;
            end
        end else if (w_push) begin
            r_mem_result[r_wptr] <= in_result;
            r_mem_op[r_wptr]     <= in_op;
            r_mem_flags[r_wptr]  <= w_flags;
        end
    end

    assign out_result = r_mem_result[r_rptr];
    assign out_op     = r_mem_op[r_rptr];
    assign out_flags  = r_mem_flags[r_rptr];

`ifdef ALU_RESULT_STAGE_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 4'b0000;
        end else if (sticky_clr) begin
            r_sticky <= 4'b0000;
        end else if (w_pop) begin
            r_sticky <= r_sticky | out_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr = sticky_clr;
    assign sticky_flags = 4'b0000;
`endif

endmodule
`default_nettype wire
